// File: rtl/inst_rom_arb_pkg.sv
// Shared constants for the instruction-ROM arbiter: ROM geometry, chip-enable levels,
// the zero data word and the response-phase state encoding.
package inst_rom_arb_pkg;

  localparam int ROM_LOG2 = 17;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_RESP_IF = 2'd1;
  localparam state_t ST_RESP_LS = 2'd2;

endpackage

// File: rtl/inst_rom_arb.sv
// Shares one combinational instruction ROM between fetch (IF) and load (LS) ports.
// LS has fixed priority; a starvation counter guarantees IF a slot every STARVE_LIMIT+1 cycles.
module inst_rom_arb
  import inst_rom_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int ROM_LOG2     = inst_rom_arb_pkg::ROM_LOG2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic [ADDR_W-1:0] ls_addr,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_err,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst
);

  localparam logic [3:0]        STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [DATA_W-1:0] ZERO_DATA  = DATA_W'(ZERO_WORD);

  state_t            state_q, state_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              ls_err_q, ls_err_d;

  logic              starve_hit;
  logic              ls_addr_bad;

  assign starve_hit  = if_req && (starve_cnt_q == STARVE_MAX);
  assign ls_addr_bad = (ls_addr[1:0] != 2'b00) || ((ls_addr >> (ROM_LOG2 + 2)) != '0);

  // Grants are gated by reset so nothing reaches the ROM while the block is held in reset.
  always_comb begin
    ls_gnt   = rst && ls_req && !starve_hit;
    if_gnt   = rst && if_req && !ls_gnt;
    rom_ce   = (if_gnt || ls_gnt) ? CHIP_ENABLE : CHIP_DISABLE;
    rom_addr = '0;
    if (ls_gnt) begin
      rom_addr = ls_addr;
    end else if (if_gnt) begin
      rom_addr = if_addr;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req || if_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (ls_gnt && (starve_cnt_q < STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // The state records which port owns the response phase in the following cycle.
  always_comb begin
    state_d    = ST_IDLE;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    ls_err_d   = 1'b0;
    if (ls_gnt) begin
      state_d    = ST_RESP_LS;
      ls_rdata_d = ls_addr_bad ? ZERO_DATA : rom_inst;
      ls_err_d   = ls_addr_bad;
    end else if (if_gnt) begin
      state_d    = ST_RESP_IF;
      if_rdata_d = rom_inst;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= 4'd0;
      if_rdata_q   <= ZERO_DATA;
      ls_rdata_q   <= ZERO_DATA;
      ls_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      if_rdata_q   <= if_rdata_d;
      ls_rdata_q   <= ls_rdata_d;
      ls_err_q     <= ls_err_d;
    end
  end

  assign if_rvalid = (state_q == ST_RESP_IF);
  assign ls_rvalid = (state_q == ST_RESP_LS);
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign ls_err    = ls_err_q;

endmodule
